fir_out_err_gen: RTL and testbench

- Reader side of the adaptive-filter weight path.
- Serially computes the filter output y(n) = sum w_i·x(n−i) by reading weights one per cycle from the weight bank that the update terms write.
- Forms the error e = d − y, then the step-scaled error mu_error = round(mu·e) that the weight-update terms consume.
- Uses the same Q(WIDTH−QP).QP fixed-point format and round-half-up convention as the update path.

---
 rtl/saf_fixp_pkg.sv | 35 +++
 rtl/round_sat_shift.sv | 19 +
 rtl/fir_out_err_gen.sv | 128 ++++++++++++
 tb/tb_fir_out_err_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/saf_fixp_pkg.sv
// Fixed-point helpers shared by the adaptive-filter weight-update and output/error paths.
package saf_fixp_pkg;

    typedef enum logic [2:0] {IDLE, RD, LAST, ERR, MU, DONE} state_e;

    localparam int FIXP_W  = 64;
    localparam int FIXP_QP = 12;

    typedef logic signed [FIXP_W-1:0] fixw_t;

    localparam fixw_t ROUND_HALF = fixw_t'(1) <<< (FIXP_QP - 1);

    // Round-half-up then arithmetic shift; the half-LSB constant is rescaled for other QP values.
    function automatic fixw_t round_shr(input fixw_t v, input int qp);
        fixw_t half;
        if (qp >= FIXP_QP)
            half = ROUND_HALF <<< (qp - FIXP_QP);
        else
            half = ROUND_HALF >>> (FIXP_QP - qp);
        return (v + half) >>> qp;
    endfunction

    function automatic fixw_t sat_to(input fixw_t v, input int w);
        fixw_t hi;
        fixw_t lo;
        hi = (fixw_t'(1) <<< (w - 1)) - fixw_t'(1);
        lo = -(fixw_t'(1) <<< (w - 1));
        if (v > hi)
            return hi;
        if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/round_sat_shift.sv
// Combinational round-half-up, arithmetic right shift by QP and saturation to WIDTH bits.
module round_sat_shift #(
    parameter int IN_W  = 32,
    parameter int WIDTH = 16,
    parameter int QP    = 12
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [WIDTH-1:0] dout_o
);
    import saf_fixp_pkg::*;

    fixw_t ext_w;

    always_comb begin
        ext_w  = fixw_t'(din_i);
        dout_o = WIDTH'(sat_to(round_shr(ext_w, QP), WIDTH));
    end

endmodule

// File: rtl/fir_out_err_gen.sv
// Serial FIR output y = sum w_i*x(n-i), error e = d - y and step-scaled error round(mu*e).
module fir_out_err_gen #(
    parameter int WIDTH = 16,
    parameter int QP    = 12,
    parameter int TAPS  = 8,
    parameter int AW    = $clog2(TAPS),
    parameter int ACC_W = 2*WIDTH + $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] d_in,
    input  logic signed [WIDTH-1:0] mu,
    output logic                    w_rd_en,
    output logic [AW-1:0]           w_addr,
    input  logic signed [WIDTH-1:0] w_data,
    output logic                    busy,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] e_out,
    output logic signed [WIDTH-1:0] mu_error
);
    import saf_fixp_pkg::*;

    state_e                  state_q, state_d;
    logic [AW-1:0]           idx_q;
    logic signed [WIDTH-1:0] x_q [TAPS];
    logic signed [WIDTH-1:0] d_q, mu_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [WIDTH-1:0] y_q, e_q, mue_q;

    logic                      accept;
    logic [AW-1:0]             mac_sel;
    logic signed [2*WIDTH-1:0] mac_prod, mu_prod;
    logic signed [WIDTH:0]     e_wide;
    logic signed [WIDTH-1:0]   y_rnd, e_sat, mue_rnd;

    assign accept = (state_q == IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RD;
            RD:      if (idx_q == AW'(TAPS - 1)) state_d = LAST;
            LAST:    state_d = ERR;
            ERR:     state_d = MU;
            MU:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_rd_en   = (state_q == RD);
        w_addr    = (state_q == RD) ? idx_q : '0;
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    // Weight read in cycle t returns in t+1, so the tap multiplied lags the address by one.
    always_comb begin
        mac_sel  = (state_q == LAST) ? AW'(TAPS - 1) : idx_q - AW'(1);
        mac_prod = w_data * x_q[mac_sel];
        mu_prod  = mu_q * e_q;
        e_wide   = {d_q[WIDTH-1], d_q} - {y_rnd[WIDTH-1], y_rnd};
        e_sat    = WIDTH'(sat_to(fixw_t'(e_wide), WIDTH));
    end

    round_sat_shift #(.IN_W(ACC_W), .WIDTH(WIDTH), .QP(QP)) u_y_rnd (
        .din_i  (acc_q),
        .dout_o (y_rnd)
    );

    round_sat_shift #(.IN_W(2*WIDTH), .WIDTH(WIDTH), .QP(QP)) u_mu_rnd (
        .din_i  (mu_prod),
        .dout_o (mue_rnd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++)
                x_q[k] <= '0;
            d_q   <= '0;
            mu_q  <= '0;
            acc_q <= '0;
            idx_q <= '0;
            y_q   <= '0;
            e_q   <= '0;
            mue_q <= '0;
        end else begin
            if (accept) begin
                x_q[0] <= x_in;
                for (int k = 1; k < TAPS; k++)
                    x_q[k] <= x_q[k-1];
                d_q   <= d_in;
                mu_q  <= mu;
                acc_q <= '0;
                idx_q <= '0;
            end
            if (state_q == RD) begin
                idx_q <= idx_q + AW'(1);
                if (idx_q != '0)
                    acc_q <= acc_q + ACC_W'(mac_prod);
            end
            if (state_q == LAST)
                acc_q <= acc_q + ACC_W'(mac_prod);
            if (state_q == ERR) begin
                y_q <= y_rnd;
                e_q <= e_sat;
            end
            if (state_q == MU)
                mue_q <= mue_rnd;
        end
    end

    assign y_out    = y_q;
    assign e_out    = e_q;
    assign mu_error = mue_q;

endmodule

// File: tb/tb_fir_out_err_gen.sv
// Directed bench for fir_out_err_gen with a 1-cycle-latency weight bank (TAPS=4).
module tb_fir_out_err_gen;

    localparam int WIDTH = 16;
    localparam int QP    = 12;
    localparam int TAPS  = 4;
    localparam int AW    = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic signed [WIDTH-1:0] x_in, d_in, mu;
    logic                    w_rd_en;
    logic [AW-1:0]           w_addr;
    logic signed [WIDTH-1:0] w_data;
    logic                    busy, out_valid;
    logic signed [WIDTH-1:0] y_out, e_out, mu_error;

    logic signed [WIDTH-1:0] wbank [TAPS];

    int n_chk  = 0;
    int n_pass = 0;
    int ov_cnt = 0;
    int ov0;
    int lat;
    int n_addr;
    int addr_log [8];

    fir_out_err_gen #(.WIDTH(WIDTH), .QP(QP), .TAPS(TAPS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x_in      (x_in),
        .d_in      (d_in),
        .mu        (mu),
        .w_rd_en   (w_rd_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .busy      (busy),
        .out_valid (out_valid),
        .y_out     (y_out),
        .e_out     (e_out),
        .mu_error  (mu_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en)
            w_data <= wbank[w_addr];
        if (out_valid)
            ov_cnt <= ov_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d);
        wbank[0] = 16'(a);
        wbank[1] = 16'(b);
        wbank[2] = 16'(c);
        wbank[3] = 16'(d);
    endtask

    // Accept one sample, log read addresses, stop in the DONE cycle, then step into IDLE.
    task automatic run_sample(input int xv, input int dv, input int mv);
        x_in  = 16'(xv);
        d_in  = 16'(dv);
        mu    = 16'(mv);
        start = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 1;
        n_addr = 0;
        while (!out_valid && lat < 40) begin
            if (w_rd_en && n_addr < 8) begin
                addr_log[n_addr] = int'(w_addr);
                n_addr++;
            end
            tick();
            lat++;
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x_in  = '0;
        d_in  = '0;
        mu    = '0;
        set_w(0, 0, 0, 0);
        repeat (2) tick();
        chk("rst_y", y_out, 0);
        chk("rst_e", e_out, 0);
        chk("rst_mue", mu_error, 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_rden", int'(w_rd_en), 0);
        chk("rst_addr", int'(w_addr), 0);
        reset = 1'b0;
        tick();

        // Impulse response through tap 0
        set_w(4096, 0, 0, 0);
        ov0 = ov_cnt;
        run_sample(2048, 4096, 4096);
        chk("imp_lat", lat, 8);
        chk("imp_y", y_out, 2048);
        chk("imp_e", e_out, 2048);
        chk("imp_mue", mu_error, 2048);
        chk("imp_naddr", n_addr, 4);
        for (int i = 0; i < 4; i++)
            chk("imp_addr", addr_log[i], i);
        chk("imp_ovcnt", ov_cnt - ov0, 1);

        // Sample travels down the delay line to tap 3
        do_reset(1);
        set_w(0, 0, 0, 4096);
        run_sample(2048, 0, 4096);
        chk("dl_y1", y_out, 0);
        run_sample(0, 0, 4096);
        chk("dl_y2", y_out, 0);
        run_sample(0, 0, 4096);
        chk("dl_y3", y_out, 0);
        run_sample(0, 0, 4096);
        chk("dl_y4", y_out, 2048);
        chk("dl_e4", e_out, -2048);
        chk("dl_mue4", mu_error, -2048);

        // Round-half-up at the LSB boundary
        do_reset(1);
        set_w(1, 0, 0, 0);
        run_sample(2048, 0, 0);
        chk("rnd_half_up", y_out, 1);
        set_w(-1, 0, 0, 0);
        run_sample(2047, 0, 0);
        chk("rnd_neg_small", y_out, 0);
        run_sample(2049, 0, 0);
        chk("rnd_neg_over", y_out, -1);
        chk("rnd_neg_e", e_out, 1);
        chk("rnd_neg_mue", mu_error, 0);

        // Saturation of y, e and mu_error
        do_reset(1);
        set_w(32767, 32767, 32767, 32767);
        repeat (4) run_sample(32767, -32768, 2048);
        chk("sat_y", y_out, 32767);
        chk("sat_e", e_out, -32768);
        chk("sat_mue", mu_error, -16384);

        // Starts during RD and during DONE must be ignored
        do_reset(1);
        set_w(0, 4096, 0, 0);
        ov0   = ov_cnt;
        d_in  = '0;
        mu    = '0;
        x_in  = 16'sd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        x_in  = 16'sd555;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("busy_ov_seen", int'(out_valid), 1);
        chk("busy_y1", y_out, 0);
        x_in  = 16'sd777;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_idle", int'(busy), 0);
        chk("busy_no_ov", int'(out_valid), 0);
        run_sample(300, 0, 0);
        chk("busy_y2", y_out, 100);
        chk("busy_ovcnt", ov_cnt - ov0, 2);

        // Reset during RD aborts without a result
        do_reset(1);
        set_w(4096, 0, 0, 0);
        ov0   = ov_cnt;
        x_in  = 16'sd1000;
        d_in  = '0;
        mu    = 16'sd4096;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_rden", int'(w_rd_en), 0);
        repeat (12) tick();
        chk("abort_ovcnt", ov_cnt - ov0, 0);
        chk("abort_y", y_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
